// File: rtl/alu_op_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Brief    : Opcode map, legal-opcode check and FSM state encoding for the
//            ALU operation sequencer.
// Revision : 1.0
// ============================================================================
package alu_pkg;

    localparam int unsigned ALU_OPW  = 5;

    localparam int unsigned OP_ADD  = 1;
    localparam int unsigned OP_SUB  = 2;
    localparam int unsigned OP_MUL  = 3;
    localparam int unsigned OP_DIV  = 4;
    localparam int unsigned OP_AND  = 5;
    localparam int unsigned OP_OR   = 6;
    localparam int unsigned OP_NEG  = 7;
    localparam int unsigned OP_NOT  = 8;
    localparam int unsigned OP_SHRA = 9;
    localparam int unsigned OP_SHL  = 10;
    localparam int unsigned OP_SHR  = 11;
    localparam int unsigned OP_ROL  = 14;
    localparam int unsigned OP_ROR  = 15;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD_Y  = 3'd1,
        ST_EXEC    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_RESP    = 3'd4
    } state_t;

    // Opcodes 12/13 are holes in the ALU's map; everything above 15 is unused.
    function automatic logic is_legal_op(input int unsigned op);
        return ((op >= OP_ADD) && (op <= OP_SHR)) || (op == OP_ROL) || (op == OP_ROR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_op_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_op_sequencer_if
// Brief    : Request, ALU-drive and response signals of the ALU sequencer.
// Revision : 1.0
// ============================================================================
interface alu_op_sequencer_if #(
    parameter int OPW = 5
);
    logic            req_valid;
    logic            req_ready;
    logic [OPW-1:0]  req_opcode;
    logic [31:0]     req_a;
    logic [31:0]     req_b;
    logic            y_in;
    logic [OPW-1:0]  alu_opcode;
    logic [31:0]     alu_a;
    logic [31:0]     alu_b;
    logic [63:0]     alu_result;
    logic            z_in;
    logic            done_valid;
    logic            done_ready;
    logic [31:0]     result_lo;
    logic [31:0]     result_hi;
    logic            result_err;
    logic            busy;

    // Environment side: the requester plus the attached ALU.
    modport master (
        output req_valid, req_opcode, req_a, req_b, done_ready, alu_result,
        input  req_ready, y_in, alu_opcode, alu_a, alu_b, z_in,
               done_valid, result_lo, result_hi, result_err, busy
    );

    modport slave (
        input  req_valid, req_opcode, req_a, req_b, done_ready, alu_result,
        output req_ready, y_in, alu_opcode, alu_a, alu_b, z_in,
               done_valid, result_lo, result_hi, result_err, busy
    );
endinterface
`default_nettype wire

// File: rtl/alu_op_sequencer_decode.sv
`default_nettype none
// ============================================================================
// Module   : alu_opcode_decode
// Brief    : Combinational legality check of a request opcode; optional
//            divide-by-zero detection under ALU_SEQ_DIVZERO_CHECK_EN.
// Revision : 1.0
// ============================================================================
module alu_opcode_decode
    import alu_pkg::*;
#(
    parameter int OPW = 5
) (
    input  wire logic [OPW-1:0] i_opcode,
`ifdef ALU_SEQ_DIVZERO_CHECK_EN
    input  wire logic [31:0]    i_operand_b,
    output logic                o_div_zero,
`endif
    output logic                o_legal
);

    assign o_legal = is_legal_op(int'(unsigned'(i_opcode)));

`ifdef ALU_SEQ_DIVZERO_CHECK_EN
    assign o_div_zero = (i_opcode == OPW'(OP_DIV)) && (i_operand_b == 32'd0);
`endif

endmodule
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_op_sequencer
// Brief    : Sequences one ALU operation per request (load Y, hold inputs for
//            ALU_LAT cycles, capture result, respond). ALU_SEQ_DIVZERO_CHECK_EN
//            rejects divide-by-zero without touching the ALU.
// Revision : 1.0
// ============================================================================
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int ALU_LAT = 1,
    parameter int OPW     = 5
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    alu_op_sequencer_if.slave bus
);

    state_t          r_state;
    state_t          w_next;
    logic [OPW-1:0]  r_op;
    logic [31:0]     r_a;
    logic [31:0]     r_b;
    logic [3:0]      r_cnt;
    logic [31:0]     r_lo;
    logic [31:0]     r_hi;
    logic            r_err;
    logic            w_legal;
    logic            w_reject;

`ifdef ALU_SEQ_DIVZERO_CHECK_EN
    logic            w_div_zero;

    alu_opcode_decode #(.OPW(OPW)) u_decode (
        .i_opcode    (bus.req_opcode),
        .i_operand_b (bus.req_b),
        .o_div_zero  (w_div_zero),
        .o_legal     (w_legal)
    );

    assign w_reject = !w_legal || w_div_zero;
`else
    alu_opcode_decode #(.OPW(OPW)) u_decode (
        .i_opcode (bus.req_opcode),
        .o_legal  (w_legal)
    );

    assign w_reject = !w_legal;
`endif

    always_comb begin
        w_next         = r_state;
        bus.req_ready  = 1'b0;
        bus.y_in       = 1'b0;
        bus.z_in       = 1'b0;
        bus.alu_opcode = '0;
        bus.alu_a      = '0;
        bus.alu_b      = '0;
        bus.done_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) w_next = w_reject ? ST_RESP : ST_LOAD_Y;
            end
            ST_LOAD_Y: begin
                bus.y_in  = 1'b1;
                bus.alu_b = r_b;
                w_next    = ST_EXEC;
            end
            ST_EXEC: begin
                bus.alu_opcode = r_op;
                bus.alu_a      = r_a;
                bus.alu_b      = r_b;
                if (r_cnt == 4'd0) w_next = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                bus.z_in       = 1'b1;
                bus.alu_opcode = r_op;
                bus.alu_a      = r_a;
                bus.alu_b      = r_b;
                w_next         = ST_RESP;
            end
            ST_RESP: begin
                bus.done_valid = 1'b1;
                if (bus.done_ready) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_cnt   <= '0;
            r_lo    <= '0;
            r_hi    <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        r_op <= bus.req_opcode;
                        r_a  <= bus.req_a;
                        r_b  <= bus.req_b;
                        // A rejected request answers at once with zeroed results.
                        if (w_reject) begin
                            r_lo  <= '0;
                            r_hi  <= '0;
                            r_err <= 1'b1;
                        end else begin
                            r_err <= 1'b0;
                        end
                    end
                end
                ST_LOAD_Y:  r_cnt <= 4'(ALU_LAT - 1);
                ST_EXEC:    if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
                ST_CAPTURE: begin
                    r_lo <= bus.alu_result[31:0];
                    r_hi <= bus.alu_result[63:32];
                end
                default: ;
            endcase
        end
    end

    assign bus.result_lo  = r_lo;
    assign bus.result_hi  = r_hi;
    assign bus.result_err = r_err;
    assign bus.busy       = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_op_sequencer
// Brief    : Directed checks of the ALU sequencer at ALU_LAT=1 and ALU_LAT=3.
// Revision : 1.0
// ============================================================================
module tb_alu_op_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    alu_op_sequencer_if #(.OPW(5)) bus1 ();
    alu_op_sequencer_if #(.OPW(5)) bus3 ();

    alu_op_sequencer #(.ALU_LAT(1), .OPW(5)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    alu_op_sequencer #(.ALU_LAT(3), .OPW(5)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    function automatic logic [63:0] alu_model(input logic [4:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [4:0] sh;
        sh = b[4:0];
        case (op)
            5'd1:    return {32'd0, a + b};
            5'd2:    return {32'd0, a - b};
            5'd3:    return {32'd0, a} * {32'd0, b};
            5'd4:    return (b == 32'd0) ? 64'd0 : {a % b, a / b};
            5'd14:   return {32'd0, (a << sh) | ((sh == 5'd0) ? 32'd0 : (a >> (6'd32 - {1'b0, sh})))};
            default: return 64'd0;
        endcase
    endfunction

    always_comb bus1.alu_result = alu_model(bus1.alu_opcode, bus1.alu_a, bus1.alu_b);
    always_comb bus3.alu_result = alu_model(bus3.alu_opcode, bus3.alu_a, bus3.alu_b);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n           = 1'b0;
        bus1.req_valid  = 1'b1;
        bus1.req_opcode = 5'd1;
        bus1.req_a      = 32'd1;
        bus1.req_b      = 32'd1;
        bus1.done_ready = 1'b0;
        bus3.req_valid  = 1'b0;
        bus3.req_opcode = 5'd0;
        bus3.req_a      = 32'd0;
        bus3.req_b      = 32'd0;
        bus3.done_ready = 1'b0;

        // Reset held two cycles with a pending request
        tick();
        tick();
        check("rst_ready",  64'(bus1.req_ready), 64'd1);
        check("rst_busy",   64'(bus1.busy), 64'd0);
        check("rst_done",   64'(bus1.done_valid), 64'd0);
        check("rst_yz",     64'({bus1.y_in, bus1.z_in}), 64'd0);
        check("rst_aluop",  64'(bus1.alu_opcode), 64'd0);
        check("rst_alu_ab", {bus1.alu_a, bus1.alu_b}, 64'd0);
        check("rst_result", {bus1.result_hi, bus1.result_lo}, 64'd0);
        check("rst_err",    64'(bus1.result_err), 64'd0);
        bus1.req_valid = 1'b0;
        rst_n          = 1'b1;
        tick();
        check("rst_noacc",  64'(bus1.busy), 64'd0);

        // ADD 5+7 at ALU_LAT=1
        bus1.req_valid = 1'b1; bus1.req_opcode = 5'd1; bus1.req_a = 32'd5; bus1.req_b = 32'd7;
        tick();
        bus1.req_valid = 1'b0;
        check("add_c1_y",     64'(bus1.y_in), 64'd1);
        check("add_c1_alub",  64'(bus1.alu_b), 64'd7);
        check("add_c1_ready", 64'(bus1.req_ready), 64'd0);
        tick();
        check("add_c2_exec",  {27'd0, bus1.alu_opcode, bus1.alu_a}, {27'd0, 5'd1, 32'd5});
        check("add_c2_yz",    64'({bus1.y_in, bus1.z_in}), 64'd0);
        tick();
        check("add_c3_z",     64'(bus1.z_in), 64'd1);
        check("add_c3_done",  64'(bus1.done_valid), 64'd0);
        tick();
        check("add_c4_done",  64'(bus1.done_valid), 64'd1);
        check("add_result",   {bus1.result_hi, bus1.result_lo}, 64'd12);
        check("add_err",      64'(bus1.result_err), 64'd0);
        check("add_resp_op",  64'(bus1.alu_opcode), 64'd0);
        bus1.done_ready = 1'b1;
        tick();
        bus1.done_ready = 1'b0;
        check("add_idle",     64'({bus1.done_valid, bus1.req_ready}), 64'd1);

        // Illegal opcode 12
        bus1.req_valid = 1'b1; bus1.req_opcode = 5'd12; bus1.req_a = 32'd9; bus1.req_b = 32'd9;
        tick();
        bus1.req_valid = 1'b0;
        check("ill_done",   64'(bus1.done_valid), 64'd1);
        check("ill_err",    64'(bus1.result_err), 64'd1);
        check("ill_result", {bus1.result_hi, bus1.result_lo}, 64'd0);
        check("ill_noalu",  64'({bus1.y_in, bus1.z_in, bus1.alu_opcode}), 64'd0);
        bus1.done_ready = 1'b1;
        tick();
        bus1.done_ready = 1'b0;
        check("ill_idle",   64'(bus1.req_ready), 64'd1);

        // ROL under backpressure; new request presented while busy
        bus1.req_valid = 1'b1; bus1.req_opcode = 5'd14; bus1.req_a = 32'h8000_0001; bus1.req_b = 32'd1;
        tick();
        bus1.req_opcode = 5'd1; bus1.req_a = 32'd1; bus1.req_b = 32'd1;
        tick();
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            check("rol_hold_done",  64'(bus1.done_valid), 64'd1);
            check("rol_hold_lo",    64'(bus1.result_lo), 64'h3);
            check("rol_hold_ready", 64'(bus1.req_ready), 64'd0);
            tick();
        end
        check("rol_err", 64'(bus1.result_err), 64'd0);
        bus1.done_ready = 1'b1;
        tick();
        bus1.done_ready = 1'b0;
        check("rol_after_ready", 64'(bus1.req_ready), 64'd1);
        tick();
        bus1.req_valid = 1'b0;
        check("rol_next_acc", 64'(bus1.y_in), 64'd1);
        tick();
        tick();
        tick();
        check("next_add_lo",  64'({bus1.done_valid, bus1.result_lo}), {31'd0, 1'b1, 32'd2});
        bus1.done_ready = 1'b1;
        tick();
        bus1.done_ready = 1'b0;

        // SUB 3-5 at ALU_LAT=3
        bus3.req_valid = 1'b1; bus3.req_opcode = 5'd2; bus3.req_a = 32'd3; bus3.req_b = 32'd5;
        tick();
        bus3.req_valid = 1'b0;
        check("sub_c1_y",  64'({bus3.y_in, bus3.alu_opcode}), {58'd0, 1'b1, 5'd0});
        for (int i = 0; i < 3; i++) begin
            tick();
            check("sub_exec_op", 64'({bus3.z_in, bus3.alu_opcode}), 64'd2);
        end
        tick();
        check("sub_cap", 64'({bus3.done_valid, bus3.z_in, bus3.alu_opcode}), {57'd0, 2'b01, 5'd2});
        tick();
        check("sub_c6_done", 64'(bus3.done_valid), 64'd1);
        check("sub_lo",      64'(bus3.result_lo), 64'hFFFF_FFFE);
        bus3.done_ready = 1'b1;
        tick();
        bus3.done_ready = 1'b0;

        // Reset during EXEC aborts the operation
        bus3.req_valid = 1'b1; bus3.req_opcode = 5'd1; bus3.req_a = 32'd2; bus3.req_b = 32'd3;
        tick();
        bus3.req_valid = 1'b0;
        tick();
        check("abort_in_exec", 64'(bus3.alu_opcode), 64'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort_idle",   64'({bus3.busy, bus3.req_ready, bus3.alu_opcode}), 64'b0100000);
        check("abort_result", {bus3.result_hi, bus3.result_lo}, 64'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("abort_no_done", 64'({bus3.done_valid, bus3.busy}), 64'd0);
        end

        // Divide by zero
        bus1.req_valid = 1'b1; bus1.req_opcode = 5'd4; bus1.req_a = 32'd10; bus1.req_b = 32'd0;
        tick();
        bus1.req_valid = 1'b0;
`ifdef ALU_SEQ_DIVZERO_CHECK_EN
        check("divz_done", 64'(bus1.done_valid), 64'd1);
        check("divz_err",  64'(bus1.result_err), 64'd1);
        check("divz_noalu", 64'({bus1.y_in, bus1.alu_opcode}), 64'd0);
`else
        check("divz_y", 64'(bus1.y_in), 64'd1);
        tick();
        check("divz_exec_op", 64'(bus1.alu_opcode), 64'd4);
        tick();
        tick();
        check("divz_done", 64'(bus1.done_valid), 64'd1);
        check("divz_err",  64'(bus1.result_err), 64'd0);
`endif
        bus1.done_ready = 1'b1;
        tick();
        bus1.done_ready = 1'b0;
        check("divz_idle", 64'(bus1.req_ready), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Multi-cycle controller that sequences one combinational ALU operation per request: latches the operands, strobes the Y-register load, holds the opcode and operands on the ALU for a programmable settle time, captures the 64-bit result, then returns it to the requester.
- Sits between the CPU control unit (or any micro-op issuer) and the 5-bit-opcode ALU.
- Rejects unsupported opcodes without using the ALU.

Parameters:
- ALU_LAT, 1, number of EXEC cycles the ALU inputs are held stable before capture; legal range 1..15.
- OPW, 5, opcode width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset, sampled on rising clk.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_opcode  in  OPW  ALU opcode.
- req_a  in  32  operand A (bus value).
- req_b  in  32  operand B (Y value).
- y_in  out  1  one-cycle strobe: load the Y register from alu_b.
- alu_opcode  out  OPW  opcode to the ALU.
- alu_a  out  32  operand A to the ALU.
- alu_b  out  32  operand B to the ALU.
- alu_result  in  64  ALU C output; hi = [63:32], lo = [31:0].
- z_in  out  1  one-cycle strobe: capture alu_result.
- done_valid  out  1  result available.
- done_ready  in  1  consumer accepts the result.
- result_lo  out  32  captured low word.
- result_hi  out  32  captured high word.
- result_err  out  1  request was illegal (or divide-by-zero, see Optional Feature).
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst_n=0 at a rising edge) forces state IDLE and clears every output and internal register to 0: req_ready=1 after reset, done_valid=0, y_in=0, z_in=0, alu_opcode=0, alu_a=0, alu_b=0, result_lo=0, result_hi=0, result_err=0, busy=0, counter=0.
- Reset asserted mid-operation aborts the operation; no done_valid is produced for it.
- Legal opcodes are 1–11, 14 and 15. All others (0, 12, 13, 16–31) are illegal.
- States and transitions:
  - IDLE: req_ready=1. On req_valid, latch opcode/A/B. If the opcode is legal, go to LOAD_Y; if illegal, go to RESP with result_err=1 and results 0.
  - LOAD_Y: 1 cycle; y_in=1; alu_b driven from the latched B. Next state EXEC; counter is loaded with ALU_LAT-1.
  - EXEC: alu_opcode, alu_a and alu_b driven from the latched values; counter decrements each cycle. Go to CAPTURE when counter==0 (ALU_LAT cycles total).
  - CAPTURE: 1 cycle; z_in=1; alu_* still driven. result_lo/result_hi register alu_result at the end of this cycle. Next state RESP.
  - RESP: done_valid=1. Results and result_err are held stable until done_valid & done_ready, then go to IDLE.
- alu_opcode is 0 in IDLE and RESP, so the ALU outputs 0 there.
- Latency for a legal request accepted at edge E0: done_valid rises after edge E0+3+ALU_LAT (ALU_LAT=1: 4 cycles). Illegal request: done_valid after E0+1.
- req_ready=0 outside IDLE. There is no pipelining: one request is outstanding at a time.
- Back-to-back: the cycle after the RESP handshake is IDLE, so the minimum issue interval is 4+ALU_LAT cycles.
- done_ready held high while in RESP gives a one-cycle done_valid.
- Request inputs are ignored outside IDLE; changing them mid-operation has no effect.

Optional Feature:
- Macro: ALU_SEQ_DIVZERO_CHECK_EN.
- Defined: opcode 4 (divide) with req_b==0 is treated like an illegal opcode: the ALU is not driven, and RESP follows with result_err=1 and results 0.
- Undefined: divide-by-zero is sequenced normally, result_err=0, and the result is whatever the ALU produces.

Decomposition:
- Shared package (alu_pkg):
  - Opcode localparams: OP_ADD=1, OP_SUB=2, OP_MUL=3, OP_DIV=4, OP_AND=5, OP_OR=6, OP_NEG=7, OP_NOT=8, OP_SHRA=9, OP_SHL=10, OP_SHR=11, OP_ROL=14, OP_ROR=15.
  - A legal-opcode function.
  - State encoding IDLE/LOAD_Y/EXEC/CAPTURE/RESP.
- One sub-module is natural: alu_opcode_decode, combinational, producing the legal flag (and the div-by-zero flag when the feature is enabled).

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with req_valid=1 -> no acceptance; all outputs 0 except req_ready=1 after release.
- ADD: opcode 1, A=5, B=7, ALU_LAT=1, ALU model attached -> y_in in cycle 1, z_in in cycle 3, done_valid at cycle 4, result_lo=12, result_hi=0, result_err=0.
- Illegal opcode 12 -> y_in/z_in never pulse, alu_opcode stays 0, done_valid the next cycle with result_err=1 and results 0.
- Backpressure: ROL with A=32'h80000001, B=1, done_ready low for 5 cycles -> result_lo=32'h00000003 held stable, req_ready=0 throughout; acceptance only after the handshake.
- ALU_LAT=3, SUB with A=3, B=5 -> alu_opcode=2 for 3 EXEC cycles plus CAPTURE, result_lo=32'hFFFFFFFE, done_valid 6 cycles after accept.
- Reset pulsed during EXEC -> returns to IDLE with outputs 0 and no done_valid. With ALU_SEQ_DIVZERO_CHECK_EN: DIV with B=0 -> result_err=1 with no ALU activity.
